serial_adder: RTL and testbench

Bit-serial adder: the additive counterpart of the team's full-subtractor cell, and the arithmetic inverse of serial borrow-subtract. Captures two WIDTH-bit operands plus carry-in on a start pulse. Resolves one bit per clock, LSB first, through a single gate-level full-adder cell and a carry flip-flop. Presents a held sum/carry-out with a one-cycle done pulse. Used in area-constrained datapaths where one adder cell is time-shared across all bit positions.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/full_adder1.sv | 23 ++
 rtl/serial_adder.sv | 102 ++++++++++
 tb/tb_serial_adder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_e       : controller states (IDLE, RUN)
//   SA_WIDTH_DEF  : default operand width
//   cnt_width()   : bit-position counter width for a given operand width
package serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned SA_WIDTH_DEF = 8;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder1.sv
// One-bit gate-level full-adder cell.
//   a, b, cin : addend bits and carry-in
//   sum       : a ^ b ^ cin
//   cout      : majority(a, b, cin)
module full_adder1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic axb;
  logic ab;
  logic cx;

  xor g_x0 (axb, a, b);
  xor g_x1 (sum, axb, cin);
  and g_a0 (ab, a, b);
  and g_a1 (cx, axb, cin);
  or  g_o0 (cout, ab, cx);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first,
// through a single shared full-adder cell.
//   clk, rst       : clock, synchronous active-high reset
//   start          : request, honoured only while idle
//   a, b, cin      : operands, captured on an accepted start
//   busy           : high while bits are being resolved
//   done           : one-cycle pulse when sum/cout update
//   sum, cout      : result, held between completions
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned     CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  // Only WIDTH-1 partial bits need storing: the final bit goes straight
  // from the cell into sum on the completion edge.
  logic [WIDTH-2:0] acc_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             done_q;

  logic             bit_s;
  logic             carry_d;
  logic [WIDTH-1:0] acc_d;

  full_adder1 u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (bit_s),
    .cout (carry_d)
  );

  assign acc_d = {bit_s, acc_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          carry_q <= carry_d;
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          acc_q   <= acc_d[WIDTH-1:1];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            sum_q   <= acc_d;
            cout_q  <= carry_d;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: the driver pushes expected results
// (computed with plain integer addition) tagged with the cycle they are due;
// the monitor checks done/busy/sum/cout every cycle against that queue.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           busy_from = 1;
  int           busy_to = 0;
  logic [W-1:0] hold_sum = '0;
  logic         hold_cout = 1'b0;

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      checks++;
      if (busy !== ((cyc >= busy_from) && (cyc <= busy_to))) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy,
                 (cyc >= busy_from) && (cyc <= busy_to));
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        checks++;
        if (done !== 1'b1 || sum !== sb[0].s || cout !== sb[0].c) begin
          errors++;
          $display("FAIL result cyc=%0d got done=%b sum=%h cout=%b want done=1 sum=%h cout=%b",
                   cyc, done, sum, cout, sb[0].s, sb[0].c);
        end
        hold_sum  = sb[0].s;
        hold_cout = sb[0].c;
        void'(sb.pop_front());
      end else begin
        checks++;
        if (done !== 1'b0 || sum !== hold_sum || cout !== hold_cout) begin
          errors++;
          $display("FAIL hold cyc=%0d got done=%b sum=%h cout=%b want done=0 sum=%h cout=%b",
                   cyc, done, sum, cout, hold_sum, hold_cout);
        end
      end
    end
  end

  // mode 0: drop start after accept, scramble inputs during RUN
  // mode 1: keep start and operands held (back-to-back)
  // mode 2: extra start with a=1,b=1 at RUN cycle 3 (must be ignored)
  // mode 3: reset at RUN cycle 4, operation abandoned
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input int mode);
    logic [W:0] r;
    int c;
    c = cyc;
    start = 1'b1;
    a = av;
    b = bv;
    cin = ci;
    r = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
    sb.push_back('{s: r[W-1:0], c: r[W], due: c + W + 1});
    busy_from = c + 1;
    busy_to = c + W;
    for (int i = 1; i <= W + 1; i++) begin
      @(negedge clk);
      if (i <= W) begin
        if (mode == 0) begin
          start = 1'($urandom_range(0, 1));
          a = W'($urandom);
          b = W'($urandom);
          cin = 1'($urandom_range(0, 1));
        end else if (mode == 2) begin
          start = (i == 3);
          if (i == 3) begin
            a = 8'h01;
            b = 8'h01;
          end
        end else if (mode == 3) begin
          if (i == 1) start = 1'b0;
          if (i == 4) begin
            rst = 1'b1;
            sb.delete();
            hold_sum = '0;
            hold_cout = 1'b0;
            busy_to = cyc;
          end
          if (i == 5) begin
            rst = 1'b0;
            return;
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);

    run_op(8'h35, 8'h4A, 1'b0, 2'd0);
    idle(1);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    idle(2);
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    idle(1);
    run_op(8'h10, 8'h20, 1'b0, 2);
    idle(3);
    run_op(8'h80, 8'h80, 1'b0, 1);
    run_op(8'h0F, 8'h01, 1'b1, 1);
    idle(2);
    run_op(8'h35, 8'h4A, 1'b0, 0);
    idle(1);
    run_op(8'h12, 8'h34, 1'b1, 3);
    run_op(8'h55, 8'hAA, 1'b1, 0);
    idle(1);
    run_op(8'h00, 8'h00, 1'b0, 0);

    for (int k = 0; k < 1000; k++) begin
      int m;
      m = ($urandom_range(0, 3) == 0) ? 1 : 0;
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), m);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(W + 4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
